// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch entry carries a PC field wide enough for any supported XLEN (up to 64).
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam int          FETCH_PC_MAX_W = 64;

  typedef struct packed {
    logic [31:0]               instr;
    logic [FETCH_PC_MAX_W-1:0] pc;
    logic                      misaligned;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(
    input logic [31:0]               instr,
    input logic [FETCH_PC_MAX_W-1:0] pc,
    input logic                      misaligned
  );
    fetch_entry_t e;
    e.instr      = instr;
    e.pc         = pc;
    e.misaligned = misaligned;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO with synchronous flush.
// A pop and a push in the same cycle are both honoured, including when full.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Entry storage; contents are qualified by count so it needs no reset.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else if (flush) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, request issue and a small fetch buffer.
// Optional feature macro FETCH_ALIGN_CHECK_EN reports misaligned redirect targets instead of masking them.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_4,
  output logic            if_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic            halted;
  logic            mis_pending;
  logic [XLEN-1:0] target_pc;
  logic            target_mis;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            empty;
  logic            deq;
  logic            push;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  // Redirect target conditioning.
  always_comb begin
`ifdef FETCH_ALIGN_CHECK_EN
    target_pc  = redirect_pc;
    target_mis = misaligned_target(redirect_pc);
`else
    target_pc  = redirect_pc & ~XLEN'(3);
    target_mis = 1'b0;
`endif
  end

`ifdef FETCH_ALIGN_CHECK_EN
  function automatic logic misaligned_target(input logic [XLEN-1:0] pc);
    return |pc[1:0];
  endfunction
`endif

  assign deq = if_valid && if_ready;

  // Credit the slot freed by this cycle's dequeue so a streaming decode keeps one request per cycle.
  always_comb begin
    occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
    imem_req = 1'b0;
    if (reset_n && !redirect && !halted && (int'(occ) < DEPTH)) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr = fetch_pc;

  // PC, in-flight tracking and misaligned-halt state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= XLEN'(0);
      halted      <= 1'b0;
      mis_pending <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= target_pc;
      inflight    <= 1'b0;
      halted      <= target_mis;
      mis_pending <= target_mis;
    end else begin
      if (imem_req) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      mis_pending <= 1'b0;
    end
  end

  // A returning response and a misaligned marker never coincide: the marker follows a redirect with no request.
  always_comb begin
    push = 1'b0;
    if (inflight) begin
      wr_entry = make_entry(imem_rdata, FETCH_PC_MAX_W'(inflight_pc), 1'b0);
    end else begin
      wr_entry = make_entry(32'h00000000, FETCH_PC_MAX_W'(fetch_pc), 1'b1);
    end
    if (!redirect && (inflight || mis_pending)) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (redirect),
    .push    (push),
    .wdata   (wr_entry),
    .pop     (deq),
    .rdata   (head),
    .empty   (empty),
    .count   (count)
  );

  assign if_valid      = !empty;
  assign if_instr      = if_valid ? head.instr : NOP_INSTR;
  assign if_pc         = XLEN'(head.pc);
  assign if_pc_4       = if_pc + XLEN'(4);
  assign if_misaligned = if_valid && head.misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage (XLEN=32, DEPTH=2, RESET_PC=0).
// The instruction memory returns a fixed function of the address one cycle after each request.
module tb_fetch_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata = 32'h0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_4;
  logic            if_misaligned;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_4(if_pc_4), .if_misaligned(if_misaligned)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return ~a ^ 32'h13579BDF;
  endfunction

  // Memory responder: data for an accepted request appears in the following cycle.
  always @(posedge clock) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEADBEEF;

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; redirect = 1'b0; if_ready = 1'b0; redirect_pc = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_misaligned !== 1'b0 || imem_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state: req=%b valid=%b mis=%b addr=%h, want 0 0 0 00000000",
                 imem_req, if_valid, if_misaligned, imem_addr);
      end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    if_ready = 1'b1;
    #1;
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== XLEN'(4 * j)) begin
        n_fail++;
        $display("FAIL stream_req j=%0d: req=%b addr=%h, want 1 %h", j, imem_req, imem_addr, XLEN'(4 * j));
      end
      n_cmp++;
      if (j < 2) begin
        if (if_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_early_valid j=%0d: valid=%b, want 0", j, if_valid);
        end
      end else if (if_valid !== 1'b1 || if_pc !== XLEN'(4 * (j - 2)) ||
                   if_instr !== mem_word(XLEN'(4 * (j - 2))) || if_pc_4 !== XLEN'(4 * (j - 1))) begin
        n_fail++;
        $display("FAIL stream_head j=%0d: valid=%b pc=%h instr=%h pc4=%h, want 1 %h %h %h", j, if_valid,
                 if_pc, if_instr, if_pc_4, XLEN'(4 * (j - 2)), mem_word(XLEN'(4 * (j - 2))), XLEN'(4 * (j - 1)));
      end
      step();
    end
  endtask

  task automatic test_stall();
    int nreq;
    int delivered;
    logic [XLEN-1:0] expected;
    apply_reset();
    if_ready = 1'b0;
    #1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) nreq++;
      step();
    end
    n_cmp++;
    if (nreq !== 2 || imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_full: reqs=%0d req=%b valid=%b pc=%h, want 2 0 1 00000000", nreq, imem_req, if_valid, if_pc);
    end
    if_ready = 1'b1;
    #1;
    expected = '0;
    delivered = 0;
    for (int i = 0; i < 12; i++) begin
      if (if_valid) begin
        n_cmp++;
        if (if_pc !== expected || if_instr !== mem_word(expected)) begin
          n_fail++;
          $display("FAIL stall_drain: pc=%h instr=%h, want %h %h", if_pc, if_instr, expected, mem_word(expected));
        end
        expected = expected + 32'd4;
        delivered++;
      end
      step();
    end
    n_cmp++;
    if (delivered !== 12) begin
      n_fail++;
      $display("FAIL stall_release_count: delivered=%0d, want 12", delivered);
    end
  endtask

  task automatic redirect_case(input int warm, input logic warm_ready, input logic [XLEN-1:0] tgt);
    apply_reset();
    if_ready = warm_ready;
    for (int i = 0; i < warm; i++) step();
    redirect = 1'b1; redirect_pc = tgt; if_ready = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_req_low: req=%b, want 0", imem_req);
    end
    step();
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== tgt) begin
      n_fail++;
      $display("FAIL redirect_next: valid=%b req=%b addr=%h, want 0 1 %h", if_valid, imem_req, imem_addr, tgt);
    end
    step();
    n_cmp++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_drop: valid=%b pc=%h, want valid 0", if_valid, if_pc);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (if_valid !== 1'b1 || if_pc !== tgt + XLEN'(4 * k) || if_instr !== mem_word(tgt + XLEN'(4 * k))) begin
        n_fail++;
        $display("FAIL redirect_stream k=%0d: valid=%b pc=%h instr=%h, want 1 %h %h", k, if_valid, if_pc,
                 if_instr, tgt + XLEN'(4 * k), mem_word(tgt + XLEN'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect();
    redirect_case(6, 1'b0, 32'h00000100);
    redirect_case(4, 1'b1, 32'h00000180);
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] want_addr [4];
    want_addr[0] = 32'hFFFFFFF8; want_addr[1] = 32'hFFFFFFFC; want_addr[2] = 32'h0; want_addr[3] = 32'h4;
    apply_reset();
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
    step();
    redirect = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (imem_addr !== want_addr[k]) begin
        n_fail++;
        $display("FAIL wrap_addr k=%0d: addr=%h, want %h", k, imem_addr, want_addr[k]);
      end
      if (k >= 2) begin
        n_cmp++;
        if (if_pc !== want_addr[k-2] || if_pc_4 !== want_addr[k-1]) begin
          n_fail++;
          $display("FAIL wrap_head k=%0d: pc=%h pc4=%h, want %h %h", k, if_pc, if_pc_4, want_addr[k-2], want_addr[k-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_misalign();
    apply_reset();
    if_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000102;
    step();
    redirect = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_first: valid=%b req=%b, want 0 0", if_valid, imem_req);
    end
    step();
    n_cmp++;
    if (if_valid !== 1'b1 || if_misaligned !== 1'b1 || if_pc !== 32'h102 || if_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_entry: valid=%b mis=%b pc=%h instr=%h, want 1 1 00000102 00000000",
               if_valid, if_misaligned, if_pc, if_instr);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_halt i=%0d: req=%b valid=%b, want 0 0", i, imem_req, if_valid);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h00000200;
    step();
    redirect = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_resume: req=%b addr=%h mis=%b, want 1 00000200 0", imem_req, imem_addr, if_misaligned);
    end
`else
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL align_mask_addr: req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
    end
    step();
    step();
    n_cmp++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL align_mask_head: valid=%b pc=%h mis=%b, want 1 00000100 0", if_valid, if_pc, if_misaligned);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      if_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || if_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b req=%b addr=%h mis=%b, want 0 0 00000000 0",
               if_valid, imem_req, imem_addr, if_misaligned);
    end
    step();
    reset_n = 1'b1; if_ready = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (imem_addr !== XLEN'(4 * j) || if_valid !== (j >= 2) || (j >= 2 && if_pc !== XLEN'(4 * (j - 2)))) begin
        n_fail++;
        $display("FAIL reset_restart j=%0d: addr=%h valid=%b pc=%h, want %h %b %h", j, imem_addr, if_valid,
                 if_pc, XLEN'(4 * j), (j >= 2), XLEN'(4 * (j - 2)));
      end
      step();
    end
  endtask

  // Reference: outstanding = issued - consumed since last flush; data lands one cycle after issue.
  task automatic test_random();
    int issued, consumed, landed;
    logic [XLEN-1:0] next_issue, next_cons;
    logic exp_valid, exp_req, exp_deq;
    apply_reset();
    issued = 0; consumed = 0; landed = 0;
    next_issue = 32'h0; next_cons = 32'h0;
    for (int k = 0; k < 1500; k++) begin
      if_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 40) == 0);
      redirect_pc = $urandom() & 32'hFFFFFFFC;
      #1;
      exp_valid = (landed > consumed);
      exp_deq   = exp_valid && if_ready;
      exp_req   = !redirect && ((issued - consumed - (exp_deq ? 1 : 0)) < DEPTH);
      n_cmp++;
      if (if_valid !== exp_valid || (exp_valid && (if_pc !== next_cons || if_instr !== mem_word(next_cons) ||
                                                   if_pc_4 !== next_cons + 32'd4))) begin
        n_fail++;
        $display("FAIL random_head k=%0d: valid=%b pc=%h instr=%h, want %b %h %h", k, if_valid, if_pc,
                 if_instr, exp_valid, next_cons, mem_word(next_cons));
      end
      n_cmp++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== next_issue)) begin
        n_fail++;
        $display("FAIL random_req k=%0d: req=%b addr=%h, want %b %h", k, imem_req, imem_addr, exp_req, next_issue);
      end
      if (redirect) begin
        issued = 0; consumed = 0; landed = 0;
        next_issue = redirect_pc; next_cons = redirect_pc;
      end else begin
        landed = issued;
        if (exp_req) begin
          issued++;
          next_issue = next_issue + 32'd4;
        end
        if (exp_deq) begin
          consumed++;
          next_cons = next_cons + 32'd4;
        end
      end
      @(negedge clock);
    end
    redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
